// File: rtl/snake_pkg.sv
// snake_pkg: shared FSM encoding, snake length limits and VGA line constants
// for the body RAM scheduler. The *_DEF values are the defaults used by the
// modules' parameter lists.
package snake_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, STREAM, DONE} sched_state_t;
  localparam int PIXEL_DISPLAY_BIT_DEF = 9;
  localparam int SNAKE_LENGTH_BIT_DEF  = 4;
  localparam int SNAKE_LENGTH_MAX_DEF  = 16;
  localparam int COORD_W               = 7;
  localparam int V_ACTIVE_DEF          = 480;
  localparam int V_TOTAL_DEF           = 525;
  localparam int GRANT_LAST_LINE_DEF   = 515;
  localparam int H_TOTAL               = 800;
endpackage

// File: rtl/blank_detector.sv
// blank_detector: decodes frame strobes from the VGA screen counters.
//   i_x, i_y        : screen counters
//   o_blank_entry   : first pixel of the first blanking line
//   o_grant_limit   : first pixel of the last line the updater may hold the RAM
//   o_active        : current line is visible video
module blank_detector
  import snake_pkg::*;
#(
  parameter int PIXEL_DISPLAY_BIT = PIXEL_DISPLAY_BIT_DEF,
  parameter int V_ACTIVE          = V_ACTIVE_DEF,
  parameter int V_TOTAL           = V_TOTAL_DEF,
  parameter int GRANT_LAST_LINE   = GRANT_LAST_LINE_DEF
)(
  input  logic [PIXEL_DISPLAY_BIT:0] i_x,
  input  logic [PIXEL_DISPLAY_BIT:0] i_y,
  output logic                       o_blank_entry,
  output logic                       o_grant_limit,
  output logic                       o_active
);
  localparam int W = PIXEL_DISPLAY_BIT + 1;
  // keep the limit line inside the frame so the strobe can always fire
  localparam int LIMIT_LINE = (GRANT_LAST_LINE < V_TOTAL) ? GRANT_LAST_LINE : V_TOTAL - 1;
  assign o_active      = i_y < W'(V_ACTIVE);
  assign o_blank_entry = i_y == W'(V_ACTIVE) && i_x == '0;
  assign o_grant_limit = i_y == W'(LIMIT_LINE) && i_x == '0;
endmodule

// File: rtl/body_stream_scheduler.sv
// body_stream_scheduler: owns the snake body RAM; once per frame grants it to
// the updater at blank entry, then streams every body segment to the renderer.
// Optional feature macro: UPDATE_TIMEOUT_EN (forcibly revoke a grant still held
// at GRANT_LAST_LINE, set sticky overrun, and stream anyway).
//   clock_25, reset          : pixel clock, async active-low reset
//   X, Y                     : screen counters
//   snake_length             : segments including head (0 treated as 1)
//   update_req/done/grant    : updater handshake
//   mem_rd_addr, mem_rd_x/y  : body RAM read port, 1-cycle latency
//   body_count, snake_body_x/y : segment stream to renderer (held between streams)
//   stream_busy, frame_tick, overrun : status
module body_stream_scheduler
  import snake_pkg::*;
#(
  parameter int PIXEL_DISPLAY_BIT = PIXEL_DISPLAY_BIT_DEF,
  parameter int SNAKE_LENGTH_BIT  = SNAKE_LENGTH_BIT_DEF,
  parameter int SNAKE_LENGTH_MAX  = SNAKE_LENGTH_MAX_DEF,
  parameter int V_ACTIVE          = V_ACTIVE_DEF,
  parameter int V_TOTAL           = V_TOTAL_DEF,
  parameter int GRANT_LAST_LINE   = GRANT_LAST_LINE_DEF
)(
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic [PIXEL_DISPLAY_BIT:0]  X,
  input  logic [PIXEL_DISPLAY_BIT:0]  Y,
  input  logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  input  logic                        update_req,
  input  logic                        update_done,
  output logic                        update_grant,
  output logic [SNAKE_LENGTH_BIT-1:0] mem_rd_addr,
  input  logic [COORD_W-1:0]          mem_rd_x,
  input  logic [COORD_W-1:0]          mem_rd_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [COORD_W-1:0]          snake_body_x,
  output logic [COORD_W-1:0]          snake_body_y,
  output logic                        stream_busy,
  output logic                        frame_tick,
  output logic                        overrun
);
  sched_state_t                r_state;
  logic                        r_pending, r_grant, r_busy, r_tick, r_overrun;
  logic                        r_v1, r_v2;
  logic [SNAKE_LENGTH_BIT-1:0] r_n, r_addr, r_idx1, r_cnt;
  logic [COORD_W-1:0]          r_bx, r_by;
  logic                        w_blank, w_limit, w_active, w_timeout, w_go_stream, w_issue;
  logic [SNAKE_LENGTH_BIT-1:0] w_n;

  blank_detector #(
    .PIXEL_DISPLAY_BIT(PIXEL_DISPLAY_BIT),
    .V_ACTIVE(V_ACTIVE),
    .V_TOTAL(V_TOTAL),
    .GRANT_LAST_LINE(GRANT_LAST_LINE)
  ) u_blank (
    .i_x(X),
    .i_y(Y),
    .o_blank_entry(w_blank),
    .o_grant_limit(w_limit),
    .o_active(w_active)
  );

`ifdef UPDATE_TIMEOUT_EN
  // update_done on the same cycle wins over the revoke
  assign w_timeout = r_state == GRANT && !update_done && w_limit;
`else
  logic w_unused_limit;
  assign w_unused_limit = w_limit;
  assign w_timeout = 1'b0;
`endif

  // body segments = length minus head; zero length behaves like a lone head
  assign w_n = (snake_length == '0) ? '0
             : (32'(snake_length) > SNAKE_LENGTH_MAX) ? SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1)
             : snake_length - 1'b1;
  assign w_go_stream = (r_state == IDLE && w_blank && !(update_req || r_pending))
                    || (r_state == GRANT && (update_done || w_timeout));
  assign w_issue = r_state == STREAM && r_n != '0;

  // r_v1/r_idx1: address issued last cycle (RAM data valid now);
  // r_v2: renderer triple was loaded last cycle
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_grant   <= 1'b0;
      r_busy    <= 1'b0;
      r_tick    <= 1'b0;
      r_overrun <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_n       <= '0;
      r_addr    <= '0;
      r_idx1    <= '0;
      r_cnt     <= '0;
      r_bx      <= '0;
      r_by      <= '0;
    end else begin
      r_tick <= w_blank;
      r_v1   <= w_issue;
      r_v2   <= r_v1;
      r_idx1 <= r_addr;
      if (r_v1) begin
        r_cnt <= r_idx1;
        r_bx  <= mem_rd_x;
        r_by  <= mem_rd_y;
      end
      if (r_v2 && r_cnt == r_n - 1'b1) r_busy <= 1'b0;
      if (update_req && w_active) r_pending <= 1'b1;
      if (w_timeout) r_overrun <= 1'b1;
      if (w_go_stream) begin
        r_state   <= STREAM;
        r_n       <= w_n;
        r_addr    <= '0;
        r_busy    <= w_n != '0;
        r_grant   <= 1'b0;
        r_pending <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_blank) begin
            r_state <= GRANT;
            r_grant <= 1'b1;
          end
          GRANT: r_state <= GRANT;
          STREAM: if (r_n == '0 || r_addr == r_n - 1'b1) r_state <= DONE;
                  else r_addr <= r_addr + 1'b1;
          DONE: r_state <= IDLE;
        endcase
      end
    end
  end

  assign update_grant = r_grant;
  assign mem_rd_addr  = r_addr;
  assign body_count   = r_cnt;
  assign snake_body_x = r_bx;
  assign snake_body_y = r_by;
  assign stream_busy  = r_busy;
  assign frame_tick   = r_tick;
  assign overrun      = r_overrun;
endmodule

// File: tb/tb_body_stream_scheduler.sv
// tb_body_stream_scheduler: scoreboard bench; stimulus pushes expected segments,
// a negedge monitor pops and compares them while stream_busy shows valid slots.
module tb_body_stream_scheduler;
  logic       clk = 0, rst_n = 1;
  logic [9:0] X = 10'd1, Y = 10'd100;
  logic [3:0] len = 4'd4;
  logic       req = 0, done = 0;
  logic       grant, busy, tick, ovr;
  logic [3:0] addr, cnt;
  logic [6:0] rx = 0, ry = 0, bx, by;
  typedef struct {logic [3:0] c; logic [6:0] x; logic [6:0] y;} seg_t;
  seg_t sb[$];
  int n_chk = 0, n_fail = 0, bc = 0, gcnt = 0, seen = 0;

  always #5 clk = ~clk;

  body_stream_scheduler dut (
    .clock_25(clk), .reset(rst_n), .X(X), .Y(Y), .snake_length(len),
    .update_req(req), .update_done(done), .update_grant(grant),
    .mem_rd_addr(addr), .mem_rd_x(rx), .mem_rd_y(ry),
    .body_count(cnt), .snake_body_x(bx), .snake_body_y(by),
    .stream_busy(busy), .frame_tick(tick), .overrun(ovr)
  );

  function automatic logic [6:0] fx(input logic [3:0] a); return 7'(5 * a + 3); endfunction
  function automatic logic [6:0] fy(input logic [3:0] a); return 7'(100 - a); endfunction

  // body RAM model, one cycle read latency
  always @(posedge clk) begin
    rx <= fx(addr);
    ry <= fy(addr);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_stream(input int n);
    for (int k = 0; k < n; k++) sb.push_back('{4'(k), fx(4'(k)), fy(4'(k))});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic blank_entry();
    Y = 10'd480;
    X = 10'd0;
    cyc();
    X = 10'd1;
  endtask

  // segment k is valid on the (k+3)th consecutive busy cycle
  always @(negedge clk) begin
    seg_t e;
    if (!busy) bc = 0;
    else begin
      bc++;
      if (bc >= 3) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL seg_extra: got index %0d expected no segment", cnt);
        end else begin
          e = sb.pop_front();
          check("seg_idx", cnt, e.c);
          check("seg_x", bx, e.x);
          check("seg_y", by, e.y);
        end
      end
    end
  end

  initial begin
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_addr", addr, 0);
    check("rst_cnt", cnt, 0);
    check("rst_bx", bx, 0);
    check("rst_by", by, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_ovr", ovr, 0);
    cyc();
    rst_n = 1;
    cyc();
    // plain stream, length 4
    len = 4'd4;
    expect_stream(3);
    blank_entry();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 3) check("t1_addr", addr, c);
      check("t1_busy", busy, c <= 4);
      check("t1_tick", tick, c == 0);
      cyc();
    end
    repeat (3) cyc();
    @(negedge clk);
    check("t1_hold_cnt", cnt, 2);
    check("t1_hold_x", bx, fx(4'd2));
    check("t1_hold_y", by, fy(4'd2));
    // length 1 and 0: nothing streamed, outputs held
    for (int l = 1; l >= 0; l--) begin
      len = 4'(l);
      Y = 10'd100;
      cyc();
      blank_entry();
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (busy) seen++;
        cyc();
      end
      check("t2_busy_cycles", seen, 0);
      check("t2_hold_cnt", cnt, 2);
      check("t2_hold_x", bx, fx(4'd2));
    end
    // request in active video, done on the 30th grant cycle
    len = 4'd3;
    Y = 10'd100;
    req = 1;
    cyc();
    req = 0;
    repeat (5) cyc();
    expect_stream(2);
    blank_entry();
    gcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) check("t3_grant_rise", grant, 1);
      if (grant) gcnt++;
      done = grant && gcnt == 30;
      if (c == 30) begin
        check("t3_grant_fall", grant, 0);
        check("t3_stream_start", busy, 1);
        check("t3_addr0", addr, 0);
      end
      cyc();
    end
    check("t3_grant_cycles", gcnt, 30);
    // pending was cleared by done: next frame streams directly
    len = 4'd2;
    Y = 10'd100;
    cyc();
    expect_stream(1);
    blank_entry();
    @(negedge clk);
    check("t3b_no_grant", grant, 0);
    check("t3b_busy", busy, 1);
    repeat (6) cyc();
    // longest representable length (15): indices 0..13, no wrap
    len = 4'd15;
    Y = 10'd100;
    cyc();
    expect_stream(14);
    blank_entry();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 14) check("t4_addr", addr, c);
      if (c == 15) check("t4_busy_last", busy, 1);
      if (c == 16) check("t4_busy_end", busy, 0);
      cyc();
    end
    check("t4_last_cnt", cnt, 13);
    check("t4_last_x", bx, fx(4'd13));
    check("t4_sb_empty", sb.size(), 0);
    // reset in the middle of an N=5 stream at k=2
    len = 4'd6;
    Y = 10'd100;
    cyc();
    blank_entry();
    cyc();
    cyc();
    #1;
    check("t5_addr_k2", addr, 2);
    rst_n = 0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_addr", addr, 0);
    check("t5_cnt", cnt, 0);
    check("t5_bx", bx, 0);
    check("t5_by", by, 0);
    check("t5_grant", grant, 0);
    cyc();
    rst_n = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy || addr != 0) seen++;
      cyc();
    end
    check("t5_idle_after_rst", seen, 0);
    Y = 10'd100;
    cyc();
    expect_stream(5);
    blank_entry();
    repeat (10) cyc();
    // updater never finishes
    len = 4'd3;
    Y = 10'd100;
    req = 1;
    cyc();
    req = 0;
    blank_entry();
    repeat (5) cyc();
    expect_stream(2);
    Y = 10'd515;
    X = 10'd0;
    cyc();
    X = 10'd1;
    Y = 10'd516;
    @(negedge clk);
`ifdef UPDATE_TIMEOUT_EN
    check("t6_grant_revoked", grant, 0);
    check("t6_overrun", ovr, 1);
    check("t6_stream", busy, 1);
    repeat (8) cyc();
    check("t6_overrun_sticky", ovr, 1);
`else
    check("t6_grant_held", grant, 1);
    check("t6_no_overrun", ovr, 0);
    check("t6_no_stream", busy, 0);
    cyc();
    blank_entry();
    @(negedge clk);
    check("t6_grant_next_frame", grant, 1);
    check("t6_tick", tick, 1);
    check("t6_no_stream2", busy, 0);
    cyc();
    done = 1;
    cyc();
    done = 0;
    repeat (8) cyc();
    check("t6_no_overrun_end", ovr, 0);
`endif
    repeat (5) cyc();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
